// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator
//   Turns one load/store request from the EX stage into a single memory
//   transaction, then returns aligned, extended load data to the WB stage.
//
// Optional feature:
//   MEMREQ_TIMEOUT_EN - adds a BUSY-cycle watchdog and the timeout output.
//
// Parameters:
//   ADDR_W          byte-address width
//   TIMEOUT_CYCLES  BUSY cycles without mem_ack before the watchdog fires
//
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   ex_*             request from EX (valid/ready, load/store, size,
//                    unsigned, address, right-aligned store data)
//   mem_*            memory request (req/we/addr/wdata/be) and
//                    response (ack/rdata)
//   wb_valid/wb_data one-cycle load result to WB
//   misalign         one-cycle flag for a rejected misaligned access
//   timeout          one-cycle watchdog flag (MEMREQ_TIMEOUT_EN only)
//
// Handshake: a request transfers on a rising edge where ex_valid and
// ex_ready are both 1 and ex_load or ex_store is set. ex_ready depends only
// on the FSM state, so it never combinationally depends on ex_valid. On the
// memory side, mem_req and its attributes stay constant until the edge
// where mem_ack is sampled high; mem_ack outside BUSY has no effect.
module lsu_mem_initiator #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [1:0]        ex_size,
  input  logic              ex_unsigned,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic [31:0]       wb_data,
  output logic              misalign
`ifdef MEMREQ_TIMEOUT_EN
  ,
  output logic              timeout
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Visible to checkers by hierarchical reference.
  state_t state;

  // Captured request attributes needed after acceptance.
  logic       req_load;
  logic       req_unsigned;
  logic [1:0] req_size;
  logic [1:0] req_off;

  logic        accept;
  logic        mis;
  logic [3:0]  be_dec;
  logic [31:0] wdata_dec;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid && ex_ready && (ex_load || ex_store);

  // Size 11 behaves as a word everywhere, so ex_size[1] means "word".
  always_comb begin
    mis = 1'b0;
    if (ex_size == 2'b01)
      mis = ex_addr[0];
    else if (ex_size[1])
      mis = (ex_addr[1:0] != 2'b00);
  end

  always_comb begin
    be_dec    = 4'b1111;
    wdata_dec = ex_wdata;
    case (ex_size)
      2'b00: begin
        be_dec    = 4'b0001 << ex_addr[1:0];
        wdata_dec = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        be_dec    = ex_addr[1] ? 4'b1100 : 4'b0011;
        wdata_dec = {2{ex_wdata[15:0]}};
      end
      default: begin
        be_dec    = 4'b1111;
        wdata_dec = ex_wdata;
      end
    endcase
  end

  // Lane select and extension of the returned word for loads.
  always_comb begin
    case (req_off)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    rd_half = req_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (req_size)
      2'b00:   load_data = req_unsigned ? {24'd0, rd_byte}
                                        : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   load_data = req_unsigned ? {16'd0, rd_half}
                                        : {{16{rd_half[15]}}, rd_half};
      default: load_data = mem_rdata;
    endcase
  end

`ifdef MEMREQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] busy_cnt;
  logic [CNT_W-1:0] busy_cnt_next;
  // busy_cnt holds completed BUSY cycles; the watchdog fires on the edge
  // that closes the TIMEOUT_CYCLES-th BUSY cycle.
  assign busy_cnt_next = busy_cnt + CNT_W'(1);
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_load     <= 1'b0;
      req_unsigned <= 1'b0;
      req_size     <= 2'b00;
      req_off      <= 2'b00;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      mem_be       <= 4'd0;
      wb_valid     <= 1'b0;
      wb_data      <= 32'd0;
      misalign     <= 1'b0;
`ifdef MEMREQ_TIMEOUT_EN
      timeout      <= 1'b0;
      busy_cnt     <= '0;
`endif
    end else begin
      // Strobes default low so each is a single-cycle pulse.
      misalign <= 1'b0;
      wb_valid <= 1'b0;
`ifdef MEMREQ_TIMEOUT_EN
      timeout  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            // Store wins when both load and store are asserted.
            req_load     <= ex_load && !ex_store;
            req_unsigned <= ex_unsigned;
            req_size     <= ex_size;
            req_off      <= ex_addr[1:0];
            if (mis) begin
              misalign <= 1'b1;
            end else begin
              state     <= BUSY;
              mem_req   <= 1'b1;
              mem_we    <= ex_store;
              mem_addr  <= {ex_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be_dec;
              mem_wdata <= wdata_dec;
`ifdef MEMREQ_TIMEOUT_EN
              busy_cnt  <= '0;
`endif
            end
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            if (req_load) begin
              wb_valid <= 1'b1;
              wb_data  <= load_data;
            end
          end
`ifdef MEMREQ_TIMEOUT_EN
          else if (busy_cnt_next == TO_LIM) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            timeout <= 1'b1;
          end else begin
            busy_cnt <= busy_cnt_next;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases followed by
// randomized transactions checked against a behavioural model built from
// byte-lane arithmetic. Define MEMREQ_TIMEOUT_EN to also exercise the
// watchdog with TIMEOUT_CYCLES = 4.
module tb_lsu_mem_initiator;

`ifdef MEMREQ_TIMEOUT_EN
  localparam int TB_TO = 4;
`else
  localparam int TB_TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_load;
  logic        ex_store;
  logic [1:0]  ex_size;
  logic        ex_unsigned;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        misalign;
`ifdef MEMREQ_TIMEOUT_EN
  logic        timeout;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_wb;

  lsu_mem_initiator #(.ADDR_W(32), .TIMEOUT_CYCLES(TB_TO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_load(ex_load),
    .ex_store(ex_store), .ex_size(ex_size), .ex_unsigned(ex_unsigned),
    .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .misalign(misalign)
`ifdef MEMREQ_TIMEOUT_EN
    , .timeout(timeout)
`endif
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_mis(input logic [1:0] size, input logic [31:0] addr);
    if (size == 2'd1) return (addr % 2) != 0;
    if (size >= 2'd2) return (addr % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int off = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << off);
    if (size == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] wdata);
    if (size == 2'd0) return (wdata % 256) * 32'h0101_0101;
    if (size == 2'd1) return (wdata % 65536) * 32'h0001_0001;
    return wdata;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] size,
                                         input logic [31:0] addr, input bit uns);
    int     bits;
    int     shift;
    longint v;
    if (size >= 2'd2) return rdata;
    bits  = (size == 2'd0) ? 8 : 16;
    shift = (size == 2'd0) ? int'(addr % 4) * 8 : int'((addr % 4) / 2) * 16;
    v     = longint'(rdata >> shift) % (longint'(1) << bits);
    if (!uns && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  // ---------------- driver ----------------
  // Presents one request, answers after 'delay' extra BUSY cycles and
  // checks every cycle until the block is ready again.
  task automatic do_txn(input bit ld, input bit st, input logic [1:0] size, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rdata, input int delay);
    bit is_ld = ld && !st;
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_size = size;
    ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata;
    check1("ready_before_accept", ex_ready, 1'b1);
    tick();
    // Scramble the EX fields so only captured values can produce a match.
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_size = 2'($urandom); ex_unsigned = 1'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom;
    if (m_mis(size, addr)) begin
      check1("mis_pulse", misalign, 1'b1);
      check1("mis_no_req", mem_req, 1'b0);
      check1("mis_ready", ex_ready, 1'b1);
      check1("mis_no_wb", wb_valid, 1'b0);
      tick();
      check1("mis_one_cycle", misalign, 1'b0);
      check1("mis_no_req_after", mem_req, 1'b0);
      return;
    end
    for (int d = 0; d <= delay; d++) begin
      check1("busy_req", mem_req, 1'b1);
      check1("busy_we", mem_we, st);
      check("busy_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("busy_be", {28'd0, mem_be}, {28'd0, m_be(size, addr)});
      if (st) check("busy_wdata", mem_wdata, m_wdata(size, wdata));
      check1("busy_not_ready", ex_ready, 1'b0);
      check1("busy_no_wb", wb_valid, 1'b0);
      check1("busy_no_mis", misalign, 1'b0);
      mem_ack   = (d == delay);
      mem_rdata = (d == delay) ? rdata : $urandom;
      tick();
    end
    mem_ack = 1'b0; mem_rdata = $urandom;
    if (is_ld) exp_wb = m_load(rdata, size, addr, uns);
    check1("resp_req_low", mem_req, 1'b0);
    check1("resp_not_ready", ex_ready, 1'b0);
    check1("resp_wb_valid", wb_valid, is_ld);
    check("resp_wb_data", wb_data, exp_wb);
`ifdef MEMREQ_TIMEOUT_EN
    check1("resp_no_timeout", timeout, 1'b0);
`endif
    tick();
    check1("idle_ready", ex_ready, 1'b1);
    check1("idle_wb_low", wb_valid, 1'b0);
    check("idle_wb_hold", wb_data, exp_wb);
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    ex_size = 2'd0; ex_unsigned = 1'b0; ex_addr = 32'd0; ex_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; exp_wb = 32'd0;
    tick(); tick();
    check1("rst_ready", ex_ready, 1'b1);
    check1("rst_req", mem_req, 1'b0);
    check1("rst_we", mem_we, 1'b0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_be", {28'd0, mem_be}, 32'd0);
    check1("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 32'd0);
    check1("rst_misalign", misalign, 1'b0);
`ifdef MEMREQ_TIMEOUT_EN
    check1("rst_timeout", timeout, 1'b0);
`endif
    reset = 1'b0;

    // Signed byte load, accepted on the first edge after reset.
    do_txn(1, 0, 2'd0, 0, 32'h0000_0013, 32'd0, 32'h80FF_1234, 0);
    check("byte_load_result", wb_data, 32'hFFFF_FF80);
    // Half store.
    do_txn(0, 1, 2'd1, 0, 32'h0000_0022, 32'h0000_ABCD, 32'd0, 0);
    // Misaligned word load.
    do_txn(1, 0, 2'd2, 0, 32'h0000_0006, 32'd0, 32'd0, 0);
    // Unsigned half load with delayed ack.
    do_txn(1, 0, 2'd1, 1, 32'h0000_0002, 32'd0, 32'h9ABC_0000, (TB_TO > 6) ? 5 : TB_TO - 1);
    check("half_load_result", wb_data, 32'h0000_9ABC);
    // Load and store together behave as a store; size 11 as word.
    do_txn(1, 1, 2'd3, 0, 32'h0000_0100, 32'h1357_9BDF, 32'hFFFF_FFFF, 1);

    // mem_ack while idle is ignored.
    mem_ack = 1'b1; mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    check1("idle_ack_no_req", mem_req, 1'b0);
    check1("idle_ack_no_wb", wb_valid, 1'b0);
    check1("idle_ack_ready", ex_ready, 1'b1);
    check("idle_ack_wb_hold", wb_data, exp_wb);

    // Valid without load or store is not a request.
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd2; ex_addr = 32'h3;
    tick();
    ex_valid = 1'b0;
    check1("noop_ready", ex_ready, 1'b1);
    check1("noop_no_req", mem_req, 1'b0);
    check1("noop_no_mis", misalign, 1'b0);

    // Reset in the second BUSY cycle, with ex_valid and mem_ack also high.
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'd2; ex_addr = 32'h40;
    tick();
    ex_valid = 1'b0; ex_load = 1'b0;
    check1("rb_busy1", mem_req, 1'b1);
    tick();
    check1("rb_busy2", mem_req, 1'b1);
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    ex_valid = 1'b1; ex_load = 1'b1;
    tick();
    check1("rb_req_low", mem_req, 1'b0);
    check1("rb_no_wb", wb_valid, 1'b0);
    check1("rb_ready", ex_ready, 1'b1);
    check("rb_wb_data", wb_data, 32'd0);
    check("rb_addr", mem_addr, 32'd0);
    exp_wb = 32'd0;
    reset = 1'b0; mem_ack = 1'b0; ex_valid = 1'b0; ex_load = 1'b0;
    do_txn(1, 0, 2'd0, 1, 32'h0000_0081, 32'd0, 32'h00C3_A500, 0);

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      bit ld = 1'($urandom);
      bit st = ld ? 1'($urandom) : 1'b1;
      do_txn(ld, st, 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             $urandom_range(0, (TB_TO > 4) ? 4 : TB_TO - 1));
    end

`ifdef MEMREQ_TIMEOUT_EN
    // No ack: watchdog fires after TB_TO BUSY cycles; a late ack is ignored.
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_size = 2'd2; ex_addr = 32'h80;
    tick();
    ex_valid = 1'b0; ex_load = 1'b0;
    for (int d = 0; d < TB_TO; d++) begin
      check1("to_req_high", mem_req, 1'b1);
      check1("to_not_yet", timeout, 1'b0);
      tick();
    end
    check1("to_req_drop", mem_req, 1'b0);
    check1("to_pulse", timeout, 1'b1);
    check1("to_ready", ex_ready, 1'b1);
    check1("to_no_wb", wb_valid, 1'b0);
    mem_ack = 1'b1; mem_rdata = $urandom;
    tick();
    mem_ack = 1'b0;
    check1("to_one_pulse", timeout, 1'b0);
    check1("to_late_ack_no_wb", wb_valid, 1'b0);
    check1("to_late_ack_no_req", mem_req, 1'b0);
    tick();
    check1("to_late_ack_no_wb2", wb_valid, 1'b0);
    check("to_wb_hold", wb_data, exp_wb);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global bound so the run always ends.
  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
